matrix_3x3_generator: RTL and testbench
=======================================

Name: matrix_3x3_generator

Overview:
- Upstream neighbour of the 3x3 Gaussian filter stage in the canny pipeline.
- Takes a raster-order pixel stream (WIDTH x DEPTH) and buffers two previous image rows in line buffers.
- Emits one 3x3 window per accepted pixel, plus a border flag. Downstream kernels discard flagged windows, which yields a (DEPTH-2) x (WIDTH-2) output image.

Parameters:
- WIDTH, 640, pixels per row (columns).
- DEPTH, 512, rows per frame.
- DATA_WIDTH, 16, pixel width in bits.

Ports:
- clk  input  1  pipeline clock.
- rst_n  input  1  asynchronous active-low reset.
- frame_start  input  1  single-cycle pulse; restarts row/col counters for a new frame.
- per_clken  input  1  input pixel strobe; per_data is accepted when high.
- per_data  input  DATA_WIDTH  input pixel, raster order, row 0 col 0 first.
- matrix_clken  output  1  window strobe; one pulse per accepted pixel.
- border_flag  output  1  high when the current window touches the discarded border.
- matrix_p11, matrix_p12, matrix_p13  output  DATA_WIDTH each  window row r-2, cols c-2, c-1, c.
- matrix_p21, matrix_p22, matrix_p23  output  DATA_WIDTH each  window row r-1, cols c-2, c-1, c.
- matrix_p31, matrix_p32, matrix_p33  output  DATA_WIDTH each  window row r, cols c-2, c-1, c.
- frame_done  output  1  single-cycle pulse coinciding with the window of the last pixel (DEPTH-1, WIDTH-1).

Behaviour:
- Reset (async, rst_n low): all outputs 0; row/col counters 0; column shift registers 0. Line buffer RAM contents need not be cleared.
- Counters col 0..WIDTH-1 and row 0..DEPTH-1 advance only on per_clken.
  - col wraps to 0 and increments row.
  - At (DEPTH-1, WIDTH-1) both counters wrap to 0, so the next frame may follow back-to-back without frame_start.
- frame_start forces both counters to 0. If per_clken is high in the same cycle, that pixel is (0,0). A partial frame is abandoned; no frame_done is issued for it.
- Window definition: for a pixel I(r,c) accepted at cycle t, the window I(r-2..r, c-2..c) appears at cycle t+2 with matrix_clken=1 (latency exactly 2 clk). p33=I(r,c), p11=I(r-2,c-2).
- border_flag = (r<2) or (c<2) of the accepted pixel, aligned with matrix_clken. Window contents are unspecified while border_flag=1.
- matrix_clken is low in any cycle not exactly 2 cycles after a per_clken. Window outputs hold their last value when matrix_clken is low.
- Gaps in per_clken (stalls of any length) are allowed. Shift registers and line buffers update only on accepted pixels, so window content is independent of gap pattern.
- Line buffers: two, each WIDTH deep, addressed by col.
  - Read-before-write at the same address.
  - LB1 output feeds the LB2 write data.
  - Synchronous read (one registered stage), followed by a registered column shift stage, giving the 2-cycle latency.
- Non-border windows per frame: (DEPTH-2)*(WIDTH-2), i.e. 325380 at defaults.
- Counter widths: $clog2(WIDTH) and $clog2(DEPTH).
- No backpressure: the downstream stage must accept every window.

Decomposition:
- Shared package holds:
  - DATA_WIDTH default;
  - IMG_WIDTH = 640;
  - IMG_DEPTH = 512;
  - derived counter widths.
- One sub-module, line_buffer: single-port-style circular RAM with WIDTH entries, synchronous read, write-enable on per_clken. Instantiated twice.

Test Plan:
- WIDTH=4, DEPTH=4, pixel value = r*16+c, continuous per_clken.
  - Window for (2,2): p11..p13=0x00,0x01,0x02; p21..p23=0x10,0x11,0x12; p31..p33=0x20,0x21,0x22; border_flag=0.
  - Exactly 4 non-border windows per frame; frame_done on the (3,3) window.
- Same frame with random 0-5 cycle gaps in per_clken -> identical non-border window sequence. Each matrix_clken occurs exactly 2 cycles after its per_clken.
- frame_start pulsed at pixel (2,1) of frame 1, then a full frame 2 (value = 0x80+r*16+c) -> no frame_done for frame 1. Frame 2 window (2,2) has p11=0x80, p33=0xA2.
- rst_n asserted mid-frame at (3,1) -> all outputs 0 immediately. After release, a new frame produces a correct (2,2) window.
- Default params, two back-to-back frames without frame_start -> 325380 non-border windows per frame, two frame_done pulses.
- Border check, WIDTH=4, DEPTH=4 -> border_flag=1 for all row-0/1 and col-0/1 pixels (12 windows per frame).

Source files
------------

// File: rtl/matrix_3x3_generator_pkg.sv
// ----------------------------------------------------------------------------
// matrix_3x3_generator_pkg
//
// Shared definitions for the 3x3 window generator that feeds the Gaussian
// stage of the canny pipeline.
//   - default image geometry and pixel width
//   - derived row/column counter widths
//   - sideband record carried alongside a pixel through the read stage
// ----------------------------------------------------------------------------
package matrix_3x3_generator_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 16;
    localparam int unsigned IMG_WIDTH          = 640;
    localparam int unsigned IMG_DEPTH          = 512;

    // Counter width for a dimension of n entries. The lower bound of 1 keeps
    // degenerate geometries from producing zero-width vectors.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned IMG_COL_WIDTH = cnt_width(IMG_WIDTH);
    localparam int unsigned IMG_ROW_WIDTH = cnt_width(IMG_DEPTH);

    // Sideband of an accepted pixel, registered together with the line
    // buffer reads so it lines up with the window it describes.
    typedef struct packed {
        logic valid;   // a pixel was accepted in the previous cycle
        logic border;  // that pixel lies in row 0/1 or column 0/1
        logic last;    // that pixel is (DEPTH-1, WIDTH-1)
    } side_t;

endpackage

// File: rtl/matrix_3x3_generator_line_buffer.sv
// ----------------------------------------------------------------------------
// matrix_3x3_generator_line_buffer
//
// One image row of storage, addressed by column. Synchronous read through a
// single output register; a write and a read to the same address in the same
// cycle return the old contents (read-before-write). RAM contents are not
// reset, only the read register is.
//
// Ports:
//   clk    pipeline clock
//   rst_n  asynchronous active-low reset (clears rdata only)
//   re     read enable, loads rdata from mem[raddr]
//   raddr  read column address
//   we     write enable
//   waddr  write column address
//   wdata  write data
//   rdata  registered read data
// ----------------------------------------------------------------------------
module matrix_3x3_generator_line_buffer #(
    parameter int unsigned ENTRIES    = 640,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [ENTRIES];

    // Kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/matrix_3x3_generator.sv
// ----------------------------------------------------------------------------
// matrix_3x3_generator
//
// Turns a raster-order pixel stream into one 3x3 window per accepted pixel.
// Two line buffers hold rows r-1 and r-2; a column shift stage builds the
// three columns c-2..c. Window for pixel I(r,c) accepted in cycle t appears in
// cycle t+2 with matrix_clken high. Windows touching row 0/1 or column 0/1
// carry border_flag and have unspecified contents.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   frame_start             restarts row/col counters (same-cycle pixel is 0,0)
//   per_clken, per_data     input pixel strobe and data
//   matrix_clken            window strobe, one per accepted pixel
//   border_flag             window touches the discarded border
//   matrix_p11..p13         row r-2, columns c-2, c-1, c
//   matrix_p21..p23         row r-1, columns c-2, c-1, c
//   matrix_p31..p33         row r,   columns c-2, c-1, c
//   frame_done              pulse with the window of pixel (DEPTH-1, WIDTH-1)
// ----------------------------------------------------------------------------
module matrix_3x3_generator
    import matrix_3x3_generator_pkg::*;
#(
    parameter int unsigned WIDTH      = IMG_WIDTH,
    parameter int unsigned DEPTH      = IMG_DEPTH,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  per_clken,
    input  logic [DATA_WIDTH-1:0] per_data,
    output logic                  matrix_clken,
    output logic                  border_flag,
    output logic [DATA_WIDTH-1:0] matrix_p11,
    output logic [DATA_WIDTH-1:0] matrix_p12,
    output logic [DATA_WIDTH-1:0] matrix_p13,
    output logic [DATA_WIDTH-1:0] matrix_p21,
    output logic [DATA_WIDTH-1:0] matrix_p22,
    output logic [DATA_WIDTH-1:0] matrix_p23,
    output logic [DATA_WIDTH-1:0] matrix_p31,
    output logic [DATA_WIDTH-1:0] matrix_p32,
    output logic [DATA_WIDTH-1:0] matrix_p33,
    output logic                  frame_done
);

    localparam int unsigned ColW = cnt_width(WIDTH);
    localparam int unsigned RowW = cnt_width(DEPTH);

    localparam logic [ColW-1:0] ColLast = ColW'(WIDTH - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(DEPTH - 1);

    // ------------------------------------------------------------------
    // Raster position of the pixel presented this cycle
    // ------------------------------------------------------------------
    logic [ColW-1:0] col_q, col_d, col_cur;
    logic [RowW-1:0] row_q, row_d, row_cur;
    logic            pix_border;
    logic            pix_last;

    always_comb begin
        // frame_start overrides the stored position so a coincident pixel
        // is taken as (0,0) of the new frame.
        col_cur = frame_start ? '0 : col_q;
        row_cur = frame_start ? '0 : row_q;
        col_d   = col_cur;
        row_d   = row_cur;
        if (per_clken) begin
            if (col_cur == ColLast) begin
                col_d = '0;
                row_d = (row_cur == RowLast) ? '0 : row_cur + 1'b1;
            end else begin
                col_d = col_cur + 1'b1;
            end
        end
    end

    assign pix_border = (row_cur <= RowW'(1)) || (col_cur <= ColW'(1));
    assign pix_last   = (row_cur == RowLast) && (col_cur == ColLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: line buffer reads, current pixel and sideband
    // ------------------------------------------------------------------
    side_t                 s1_q;
    logic [DATA_WIDTH-1:0] pix_q;
    logic [ColW-1:0]       col_s1_q;
    logic [DATA_WIDTH-1:0] lb1_rdata;  // I(r-1, c)
    logic [DATA_WIDTH-1:0] lb2_rdata;  // I(r-2, c)

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= '0;
            pix_q    <= '0;
            col_s1_q <= '0;
        end else begin
            s1_q.valid  <= per_clken;
            s1_q.border <= pix_border;
            s1_q.last   <= pix_last;
            if (per_clken) begin
                pix_q    <= per_data;
                col_s1_q <= col_cur;
            end
        end
    end

    // LB1 holds the previous row: read the old entry, then overwrite it with
    // the incoming pixel.
    matrix_3x3_generator_line_buffer #(
        .ENTRIES    (WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ColW)
    ) u_lb1 (
        .clk   (clk),
        .rst_n (rst_n),
        .re    (per_clken),
        .raddr (col_cur),
        .we    (per_clken),
        .waddr (col_cur),
        .wdata (per_data),
        .rdata (lb1_rdata)
    );

    // LB2 holds the row before that. It is fed from the registered LB1
    // output, so its write lands one cycle after the matching read, at the
    // column remembered in col_s1_q. The read for this pixel has already
    // happened by then, which preserves read-before-write ordering.
    matrix_3x3_generator_line_buffer #(
        .ENTRIES    (WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ColW)
    ) u_lb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .re    (per_clken),
        .raddr (col_cur),
        .we    (s1_q.valid),
        .waddr (col_s1_q),
        .wdata (lb1_rdata),
        .rdata (lb2_rdata)
    );

    // ------------------------------------------------------------------
    // Stage 2: column shift; window registers hold between strobes
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            matrix_clken <= 1'b0;
            border_flag  <= 1'b0;
            frame_done   <= 1'b0;
            matrix_p11   <= '0;
            matrix_p12   <= '0;
            matrix_p13   <= '0;
            matrix_p21   <= '0;
            matrix_p22   <= '0;
            matrix_p23   <= '0;
            matrix_p31   <= '0;
            matrix_p32   <= '0;
            matrix_p33   <= '0;
        end else begin
            matrix_clken <= s1_q.valid;
            border_flag  <= s1_q.valid & s1_q.border;
            frame_done   <= s1_q.valid & s1_q.last;
            if (s1_q.valid) begin
                matrix_p11 <= matrix_p12;
                matrix_p12 <= matrix_p13;
                matrix_p13 <= lb2_rdata;
                matrix_p21 <= matrix_p22;
                matrix_p22 <= matrix_p23;
                matrix_p23 <= lb1_rdata;
                matrix_p31 <= matrix_p32;
                matrix_p32 <= matrix_p33;
                matrix_p33 <= pix_q;
            end
        end
    end

endmodule

// File: tb/tb_matrix_3x3_generator.sv
module tb_matrix_3x3_generator;

    localparam int unsigned DW = 16;
    localparam int unsigned WA = 4;
    localparam int unsigned DA = 4;
    localparam int unsigned WB = 6;
    localparam int unsigned DB = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 4x4
    logic          fs_a, en_a;
    logic [DW-1:0] d_a;
    logic          clken_a, border_a, done_a;
    logic [DW-1:0] pa [9];

    // Instance B: 6x5, back-to-back frames
    logic          fs_b, en_b;
    logic [DW-1:0] d_b;
    logic          clken_b, border_b, done_b;
    logic [DW-1:0] pb [9];

    matrix_3x3_generator #(.WIDTH(WA), .DEPTH(DA), .DATA_WIDTH(DW)) dut_a (
        .clk(clk), .rst_n(rst_n), .frame_start(fs_a), .per_clken(en_a), .per_data(d_a),
        .matrix_clken(clken_a), .border_flag(border_a),
        .matrix_p11(pa[0]), .matrix_p12(pa[1]), .matrix_p13(pa[2]),
        .matrix_p21(pa[3]), .matrix_p22(pa[4]), .matrix_p23(pa[5]),
        .matrix_p31(pa[6]), .matrix_p32(pa[7]), .matrix_p33(pa[8]),
        .frame_done(done_a)
    );

    matrix_3x3_generator #(.WIDTH(WB), .DEPTH(DB), .DATA_WIDTH(DW)) dut_b (
        .clk(clk), .rst_n(rst_n), .frame_start(fs_b), .per_clken(en_b), .per_data(d_b),
        .matrix_clken(clken_b), .border_flag(border_b),
        .matrix_p11(pb[0]), .matrix_p12(pb[1]), .matrix_p13(pb[2]),
        .matrix_p21(pb[3]), .matrix_p22(pb[4]), .matrix_p23(pb[5]),
        .matrix_p31(pb[6]), .matrix_p32(pb[7]), .matrix_p33(pb[8]),
        .frame_done(done_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic                 border;
        logic                 done;
        logic [8:0][DW-1:0]   p;
    } win_t;

    win_t win_q[$];
    int   nb_frames[$];
    logic [1:0] hist_a, hist_b;
    int   wr_b, wc_b, nb_b;

    // Instance A: strobe timing and window capture
    always @(negedge clk) begin
        if (!rst_n) begin
            hist_a <= '0;
        end else begin
            check("lat_a", 32'(clken_a), 32'(hist_a[1]));
            if (clken_a) begin
                win_q.push_back(win_t'({border_a, done_a, pa[8], pa[7], pa[6], pa[5], pa[4],
                                        pa[3], pa[2], pa[1], pa[0]}));
            end
            hist_a <= {hist_a[0], en_a};
        end
    end

    // Instance B: strobe timing, window content by raster position, per-frame counts
    always @(negedge clk) begin
        if (!rst_n) begin
            hist_b <= '0;
            wr_b   <= 0;
            wc_b   <= 0;
            nb_b   <= 0;
        end else begin
            check("lat_b", 32'(clken_b), 32'(hist_b[1]));
            if (clken_b) begin
                check("b_border", 32'(border_b), 32'((wr_b < 2) || (wc_b < 2)));
                check("b_done", 32'(done_b), 32'((wr_b == DB - 1) && (wc_b == WB - 1)));
                if (!((wr_b < 2) || (wc_b < 2))) begin
                    check("b_p11", 32'(pb[0]), (wr_b - 2) * 16 + wc_b - 2);
                    check("b_p22", 32'(pb[4]), (wr_b - 1) * 16 + wc_b - 1);
                    check("b_p33", 32'(pb[8]), wr_b * 16 + wc_b);
                end
                if (done_b) begin
                    nb_frames.push_back(nb_b + (border_b ? 0 : 1));
                    nb_b <= 0;
                end else begin
                    nb_b <= nb_b + (border_b ? 0 : 1);
                end
                if (wc_b == WB - 1) begin
                    wc_b <= 0;
                    wr_b <= (wr_b == DB - 1) ? 0 : wr_b + 1;
                end else begin
                    wc_b <= wc_b + 1;
                end
            end
            hist_b <= {hist_b[0], en_b};
        end
    end

    task automatic drive_a(input logic en, input logic [DW-1:0] d, input logic fs);
        @(posedge clk);
        #1;
        en_a = en;
        d_a  = d;
        fs_a = fs;
    endtask

    task automatic drive_b(input logic en, input logic [DW-1:0] d);
        @(posedge clk);
        #1;
        en_b = en;
        d_b  = d;
    endtask

    // Pixels first..first+count-1 of a 4x4 frame, value base + r*16 + c
    task automatic send_a(input int base, input int first, input int count, input int max_gap,
                          input logic fs_first);
        int gap;
        for (int k = first; k < first + count; k++) begin
            gap = int'($urandom_range(max_gap, 0));
            repeat (gap) drive_a(1'b0, '0, 1'b0);
            drive_a(1'b1, DW'(base + (k / WA) * 16 + (k % WA)), fs_first && (k == first));
        end
        drive_a(1'b0, '0, 1'b0);
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Checks a full 4x4 frame of captured windows, then empties the queue
    task automatic check_frame_a(input string tag, input int base);
        int nb;
        int r, c;
        nb = 0;
        check({tag, "_count"}, win_q.size(), 16);
        for (int k = 0; k < win_q.size() && k < 16; k++) begin
            r = k / WA;
            c = k % WA;
            check({tag, "_border"}, 32'(win_q[k].border), 32'((r < 2) || (c < 2)));
            check({tag, "_done"}, 32'(win_q[k].done), 32'(k == 15));
            if (!win_q[k].border) nb++;
            if (!((r < 2) || (c < 2))) begin
                for (int i = 0; i < 9; i++) begin
                    check({tag, "_pix"}, 32'(win_q[k].p[i]),
                          base + (r - 2 + i / 3) * 16 + (c - 2 + i % 3));
                end
            end
        end
        check({tag, "_nb"}, nb, 4);
        win_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        fs_a = 1'b0; en_a = 1'b0; d_a = '0;
        fs_b = 1'b0; en_b = 1'b0; d_b = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_clken", 32'(clken_a), 0);
        check("rst_border", 32'(border_a), 0);
        check("rst_done", 32'(done_a), 0);
        for (int i = 0; i < 9; i++) check("rst_p", 32'(pa[i]), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Continuous frame
        send_a(0, 0, 16, 0, 1'b0);
        settle();
        check("t1_p11", 32'(win_q[10].p[0]), 'h00);
        check("t1_p13", 32'(win_q[10].p[2]), 'h02);
        check("t1_p21", 32'(win_q[10].p[3]), 'h10);
        check("t1_p23", 32'(win_q[10].p[5]), 'h12);
        check("t1_p31", 32'(win_q[10].p[6]), 'h20);
        check("t1_p33", 32'(win_q[10].p[8]), 'h22);
        check_frame_a("t1", 0);

        // Same frame with random gaps
        send_a(0, 0, 16, 5, 1'b0);
        settle();
        check_frame_a("t2", 0);

        // Abandon frame 1 at (2,1) with frame_start on frame 2's first pixel
        send_a(0, 0, 9, 0, 1'b0);
        send_a('h80, 0, 16, 2, 1'b1);
        settle();
        check("t3_count", win_q.size(), 25);
        for (int k = 0; k < 9 && k < win_q.size(); k++) begin
            check("t3_abandon_border", 32'(win_q[k].border), 1);
            check("t3_abandon_done", 32'(win_q[k].done), 0);
        end
        repeat (9) if (win_q.size() > 0) void'(win_q.pop_front());
        check("t3_p11", 32'(win_q[10].p[0]), 'h80);
        check("t3_p33", 32'(win_q[10].p[8]), 'hA2);
        check_frame_a("t3", 'h80);

        // Reset mid-frame at pixel (3,1)
        send_a('h40, 0, 13, 0, 1'b0);
        settle();
        check("t4_pre_p33", 32'(pa[8]), 'h70);
        @(posedge clk);
        #1;
        en_a = 1'b1;
        d_a  = 'h71;
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_rst_clken", 32'(clken_a), 0);
        check("t4_rst_border", 32'(border_a), 0);
        check("t4_rst_done", 32'(done_a), 0);
        for (int i = 0; i < 9; i++) check("t4_rst_p", 32'(pa[i]), 0);
        en_a = 1'b0;
        d_a  = '0;
        repeat (2) @(posedge clk);
        #1;
        win_q.delete();
        rst_n = 1'b1;
        send_a('h40, 0, 16, 3, 1'b0);
        settle();
        check("t4_p11", 32'(win_q[10].p[0]), 'h40);
        check("t4_p33", 32'(win_q[10].p[8]), 'h62);
        check_frame_a("t4", 'h40);

        // Two back-to-back 6x5 frames, no frame_start
        for (int k = 0; k < 2 * int'(WB * DB); k++) begin
            drive_b(1'b1, DW'(((k % int'(WB * DB)) / WB) * 16 + (k % WB)));
        end
        drive_b(1'b0, '0);
        settle();
        check("t5_frames", nb_frames.size(), 2);
        check("t5_nb0", nb_frames[0], (DB - 2) * (WB - 2));
        check("t5_nb1", nb_frames[1], (DB - 2) * (WB - 2));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
